// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects,
// mult/div tracker state encoding and the forwarding-select helper.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Youngest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic             mem_reg_wr,
        input logic [REG_W-1:0] mem_dst,
        input logic             wb_reg_wr,
        input logic [REG_W-1:0] wb_dst,
        input logic [REG_W-1:0] src
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (mem_reg_wr && (mem_dst != '0) && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_wr && (wb_dst != '0) && (wb_dst == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Tracks an in-flight mult/div: counts down from issue until HI/LO are valid.
module md_busy_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done
);

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start seen while BUSY is ignored; the running count is never reloaded.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside decode: EX forwarding selects, load-use / HI-LO
// stalls, branch flush and mult/div busy tracking.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_to_reg,
    input  logic             ex_md_start,
    input  logic             ex_br_taken,
    input  logic             mem_reg_wr,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             wb_reg_wr,
    input  logic [REG_W-1:0] wb_dst,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             clr_ex,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             md_busy,
    output logic             md_done
);

    logic md_issue;
    logic trk_busy;
    logic trk_done;
    logic lu;
    logic hl;

    assign md_issue = ex_valid && ex_md_start;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy_tracker (
        .clk   (clk),
        .rst_n (reset),
        .start (md_issue),
        .busy  (trk_busy),
        .done  (trk_done)
    );

    assign lu = ex_valid && ex_mem_to_reg && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign hl = id_uses_hilo && (trk_busy || md_issue);

    // Branch outranks stalls: the wrong-path ID instruction is being discarded.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        clr_ex  = 1'b0;
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
        md_busy = 1'b0;
        md_done = 1'b0;
        if (reset) begin
            fwd_a   = fwd_sel(mem_reg_wr, mem_dst, wb_reg_wr, wb_dst, ex_rs);
            fwd_b   = fwd_sel(mem_reg_wr, mem_dst, wb_reg_wr, wb_dst, ex_rt);
            md_busy = trk_busy;
            md_done = trk_done;
            if (ex_br_taken) begin
                flush_d = 1'b1;
                clr_ex  = 1'b1;
            end else if (hl || lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                clr_ex  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes reference-model
// expectations, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int unsigned L = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_uses_hilo;
        logic       ex_valid;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       ex_mem_to_reg;
        logic       ex_md_start;
        logic       ex_br_taken;
        logic       mem_reg_wr;
        logic [4:0] mem_dst;
        logic       wb_reg_wr;
        logic [4:0] wb_dst;
    } stim_t;

    typedef struct packed {
        logic       stall_f;
        logic       stall_d;
        logic       flush_d;
        logic       clr_ex;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       md_busy;
        logic       md_done;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_dst, wb_dst;
    logic       id_uses_rt, id_uses_hilo, ex_valid, ex_mem_to_reg;
    logic       ex_md_start, ex_br_taken, mem_reg_wr, wb_reg_wr;
    logic       stall_f, stall_d, flush_d, clr_ex, md_busy, md_done;
    logic [1:0] fwd_a, fwd_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_at = 0;
    exp_t q[$];
    int   qcyc[$];

    pipe_hazard_ctrl #(.MD_LATENCY(L), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_md_start(ex_md_start), .ex_br_taken(ex_br_taken),
        .mem_reg_wr(mem_reg_wr), .mem_dst(mem_dst), .wb_reg_wr(wb_reg_wr), .wb_dst(wb_dst),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .clr_ex(clr_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy), .md_done(md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(stim_t s, logic [4:0] src);
        if (s.mem_reg_wr && s.mem_dst != 0 && s.mem_dst == src) return 2'd2;
        if (s.wb_reg_wr && s.wb_dst != 0 && s.wb_dst == src) return 2'd1;
        return 2'd0;
    endfunction

    // One clock of stimulus; the model tracks the cycle at which HI/LO become valid.
    task automatic step(input stim_t s);
        exp_t e;
        logic busy, lu, hl;
        @(posedge clk);
        cyc++;
        #1;
        reset = s.rst;          id_rs = s.id_rs;           id_rt = s.id_rt;
        id_uses_rt = s.id_uses_rt; id_uses_hilo = s.id_uses_hilo;
        ex_valid = s.ex_valid;  ex_rs = s.ex_rs;           ex_rt = s.ex_rt;
        ex_mem_to_reg = s.ex_mem_to_reg; ex_md_start = s.ex_md_start;
        ex_br_taken = s.ex_br_taken; mem_reg_wr = s.mem_reg_wr; mem_dst = s.mem_dst;
        wb_reg_wr = s.wb_reg_wr; wb_dst = s.wb_dst;
        if (!s.rst) ready_at = 0;
        busy = s.rst && (cyc < ready_at);
        e = '0;
        if (s.rst) begin
            lu = s.ex_valid && s.ex_mem_to_reg && s.ex_rt != 0 &&
                 (s.ex_rt == s.id_rs || (s.id_uses_rt && s.ex_rt == s.id_rt));
            hl = s.id_uses_hilo && (busy || (s.ex_valid && s.ex_md_start));
            e.fwd_a   = ref_fwd(s, s.ex_rs);
            e.fwd_b   = ref_fwd(s, s.ex_rt);
            e.md_busy = busy;
            e.md_done = busy && (cyc == ready_at - 1);
            if (s.ex_br_taken) begin
                e.flush_d = 1'b1;
                e.clr_ex  = 1'b1;
            end else if (hl || lu) begin
                e.stall_f = 1'b1;
                e.stall_d = 1'b1;
                e.clr_ex  = 1'b1;
            end
            if (s.ex_valid && s.ex_md_start && !busy) ready_at = cyc + L;
        end
        q.push_back(e);
        qcyc.push_back(cyc);
    endtask

    task automatic chk(input string name, input int c, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   c;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                c = qcyc.pop_front();
                chk("stall_f", c, {1'b0, stall_f}, {1'b0, e.stall_f});
                chk("stall_d", c, {1'b0, stall_d}, {1'b0, e.stall_d});
                chk("flush_d", c, {1'b0, flush_d}, {1'b0, e.flush_d});
                chk("clr_ex",  c, {1'b0, clr_ex},  {1'b0, e.clr_ex});
                chk("fwd_a",   c, fwd_a, e.fwd_a);
                chk("fwd_b",   c, fwd_b, e.fwd_b);
                chk("md_busy", c, {1'b0, md_busy}, {1'b0, e.md_busy});
                chk("md_done", c, {1'b0, md_done}, {1'b0, e.md_done});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        stim_t s;
        reset = 1'b0;
        {id_rs, id_rt, ex_rs, ex_rt, mem_dst, wb_dst} = '0;
        {id_uses_rt, id_uses_hilo, ex_valid, ex_mem_to_reg} = '0;
        {ex_md_start, ex_br_taken, mem_reg_wr, wb_reg_wr} = '0;

        // Reset with busy-looking inputs: everything must read zero.
        s = '0;
        s.mem_reg_wr = 1; s.mem_dst = 5; s.ex_rs = 5; s.ex_br_taken = 1;
        step(s);
        step(s);

        // Forwarding: MEM beats WB, then WB once MEM targets r0.
        s = '0; s.rst = 1;
        s.mem_reg_wr = 1; s.mem_dst = 5; s.wb_reg_wr = 1; s.wb_dst = 5; s.ex_rs = 5;
        step(s);
        s.mem_dst = 0;
        step(s);

        // Load-use for one cycle, then bubble, then load into r0.
        s = '0; s.rst = 1;
        s.ex_valid = 1; s.ex_mem_to_reg = 1; s.ex_rt = 8; s.id_rs = 8;
        step(s);
        s.ex_valid = 0;
        step(s);
        s.ex_valid = 1; s.ex_rt = 0; s.id_rs = 0;
        step(s);

        // Branch outranks load-use.
        s.ex_rt = 8; s.id_rs = 8; s.ex_br_taken = 1;
        step(s);

        // Mult/div with a HI/LO consumer held in ID; issue-cycle hazard included.
        s = '0; s.rst = 1;
        s.ex_valid = 1; s.ex_md_start = 1; s.id_uses_hilo = 1;
        step(s);
        s.ex_md_start = 0; s.ex_valid = 0;
        repeat (5) step(s);

        // md issued together with a taken branch.
        s = '0; s.rst = 1; s.ex_valid = 1; s.ex_md_start = 1; s.ex_br_taken = 1;
        step(s);
        s = '0; s.rst = 1;
        step(s);

        // Reset mid-busy: abandon the count, no done pulse afterwards.
        s.rst = 0;
        step(s);
        s.rst = 1; s.id_uses_hilo = 1;
        repeat (4) step(s);

        // Randomized traffic on a small register range to provoke matches.
        for (int i = 0; i < 600; i++) begin
            s.rst           = ($urandom_range(0, 59) != 0);
            s.id_rs         = 5'($urandom_range(0, 3));
            s.id_rt         = 5'($urandom_range(0, 3));
            s.id_uses_rt    = 1'($urandom);
            s.id_uses_hilo  = ($urandom_range(0, 3) == 0);
            s.ex_valid      = ($urandom_range(0, 3) != 0);
            s.ex_rs         = 5'($urandom_range(0, 3));
            s.ex_rt         = 5'($urandom_range(0, 3));
            s.ex_mem_to_reg = 1'($urandom);
            s.ex_md_start   = ($urandom_range(0, 7) == 0);
            s.ex_br_taken   = ($urandom_range(0, 7) == 0);
            s.mem_reg_wr    = 1'($urandom);
            s.mem_dst       = 5'($urandom_range(0, 3));
            s.wb_reg_wr     = 1'($urandom);
            s.wb_dst        = 5'($urandom_range(0, 3));
            step(s);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS pipeline. Sequences the issue-execute pipeline register by driving its clr input, and stalls the fetch and decode stages.
- Generates EX-stage operand forwarding selects.
- Tracks a multi-cycle multiply/divide unit with a busy counter, so that HI/LO consumers wait for the result.
- Sits beside the decode stage and observes the ID, EX, MEM and WB stage fields.

Parameters:
- MD_LATENCY, 32: cycles from mult/div issue until HI/LO are valid. Legal range 2..63.
- CNT_W, 6: width of the busy counter. Must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  source register rs of the instruction in ID
- id_rt  in  5  source register rt of the instruction in ID
- id_uses_rt  in  1  the ID instruction reads rt as a source
- id_uses_hilo  in  1  the ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- ex_valid  in  1  the EX stage holds a valid instruction
- ex_rs  in  5  rs of the EX instruction
- ex_rt  in  5  rt of the EX instruction
- ex_mem_to_reg  in  1  the EX instruction is a load
- ex_md_start  in  1  the EX instruction is a mult/div being issued
- ex_br_taken  in  1  a branch or jump resolved taken in EX
- mem_reg_wr  in  1  the MEM instruction writes the register file
- mem_dst  in  5  destination register of the MEM instruction
- wb_reg_wr  in  1  the WB instruction writes the register file
- wb_dst  in  5  destination register of the WB instruction
- stall_f  out  1  hold the PC and the IF/ID register
- stall_d  out  1  hold the ID stage
- flush_d  out  1  clear the IF/ID register
- clr_ex  out  1  drives the clr input of the issue-execute register (inserts a bubble)
- fwd_a  out  2  EX operand A select: 00 = register file, 01 = WB, 10 = MEM
- fwd_b  out  2  EX operand B select, same encoding as fwd_a
- md_busy  out  1  mult/div in flight
- md_done  out  1  one-cycle pulse when HI/LO become valid

Behaviour:
- Reset:
  - While reset is low: state=IDLE, counter=0.
  - All outputs are forced to 0, regardless of any input.
- Forwarding (combinational, no latency):
  - fwd_a=10 if mem_reg_wr && mem_dst!=0 && mem_dst==ex_rs.
  - Otherwise fwd_a=01 if wb_reg_wr && wb_dst!=0 && wb_dst==ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules with ex_rt in place of ex_rs.
  - MEM wins over WB when both match.
- Load-use hazard (lu):
  - lu = ex_valid && ex_mem_to_reg && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- HI/LO hazard (hl):
  - hl = id_uses_hilo && (state==BUSY || (ex_valid && ex_md_start)).
- Branch (br):
  - br = ex_br_taken.
- Priority, branch over hl over lu:
  - br: flush_d=1, clr_ex=1, stall_f=0, stall_d=0. The wrong-path ID instruction is discarded, so its stall is dropped.
  - else hl or lu: stall_f=1, stall_d=1, clr_ex=1, flush_d=0.
  - else: all four outputs 0.
- State machine (registered):
  - States: IDLE, BUSY.
  - IDLE → BUSY when ex_valid && ex_md_start. Load counter=MD_LATENCY-1.
  - BUSY, counter!=1 → stay in BUSY, counter decrements by 1.
  - BUSY, counter==1 → IDLE, counter=0. md_done=1 during this cycle.
  - md_busy=1 exactly while state==BUSY.
  - md_busy is high for MD_LATENCY-1 cycles after the issue edge. HI/LO are usable by an ID instruction in the first cycle with state==IDLE.
  - ex_md_start while in BUSY cannot legally occur, because hl holds mult/div in ID. If it does occur, it is ignored: no counter reload.
  - ex_md_start && ex_br_taken in the same cycle: the md is issued (it is older than the discarded path) and the flush still applies.
  - Branch flush during BUSY does not affect the counter.
- Reset asserted mid-operation: the counter is abandoned immediately and the state returns to IDLE with no md_done pulse.
- Register 0 never triggers forwarding or a load-use stall.

Decomposition:
- Shared package: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the state encoding IDLE/BUSY.
- One sub-module, md_busy_tracker: the state machine and counter, with outputs md_busy and md_done.
- Forwarding and stall logic stay in the top module.

Test Plan:
- Forwarding: mem_reg_wr=1, mem_dst=5, wb_reg_wr=1, wb_dst=5, ex_rs=5 → fwd_a=10. Then mem_dst=0 → fwd_a=01.
- Load-use: ex_valid=1, ex_mem_to_reg=1, ex_rt=8, id_rs=8 → stall_f=stall_d=clr_ex=1 for exactly one cycle. With ex_rt=0 → no stall.
- Branch vs load-use: lu conditions held and ex_br_taken=1 → flush_d=1, clr_ex=1, stall_f=0, stall_d=0.
- Mult/div: MD_LATENCY=4, ex_md_start pulse, then id_uses_hilo=1 held → md_busy high for 3 cycles, md_done at the 3rd, stall released the following cycle.
- Issue-cycle HI/LO hazard: ex_md_start=1 and id_uses_hilo=1 in the same cycle → stall asserted that cycle.
- Reset: reset low while BUSY → all outputs 0 asynchronously. After release → state IDLE and no md_done pulse.
